type2_tx_sched: RTL and testbench
=================================

TYPE2_TX_SCHED -- requirements
Module: type2_tx_sched

Interface
REQ-001 Clock and reset SHALL be one clock and one asynchronous, active-low reset: clk_12_5m and rst_12_5m_n.
REQ-002 Ports SHALL be:
- clk_12_5m  in  1  system clock.
- rst_12_5m_n  in  1  async active-low reset.
- chn_empty  in  5  per-channel frame-empty flag; bit4 is the MPU config channel.
- chn_dval  in  5  per-channel word-valid, one-hot or zero.
- chn_data  in  18  muxed word from the granted channel; bit17 SOP, bit16 EOP.
- max_len  in  7  maximum frame length in words, 1..64.
- sched_rden  out  5  one-hot frame read request to the channels.
- fifo_rdreq  in  1  downstream pop.
- fifo_empty  out  1  output FIFO empty.
- fifo_rd_dval  out  1  pop data valid.
- fifo_rd_data  out  18  popped word.
- busy  out  1  state is not IDLE.
- err_cnt  out  8  saturating error counter.

Function
REQ-003 The block SHALL contain a 64x18 synchronous output FIFO; fifo_rd_dval SHALL assert exactly 1 cycle after fifo_rdreq when fifo_empty=0, with fifo_rd_data valid in that cycle.
REQ-004 A fifo_rdreq while empty SHALL be ignored: no dval, no pointer change.
REQ-005 States: IDLE, GRANT, READ, ABORT.
REQ-006 IDLE->GRANT SHALL occur when any chn_empty bit is 0 and FIFO free space >= max_len; otherwise the block SHALL remain in IDLE.
REQ-007 In GRANT the winner SHALL be registered by round-robin: search starts at last winner+1 mod 5; after reset the last winner is 4, so channel 0 is checked first.
REQ-008 In READ, sched_rden SHALL equal the one-hot grant, and the granted channel holds it high until the frame completes.
REQ-009 Each cycle in READ with chn_dval equal to the grant SHALL write chn_data into the FIFO and increment a 7-bit word counter.
REQ-010 A dval from a non-granted channel SHALL be discarded and SHALL increment err_cnt.
REQ-011 A write with bit16=1 (EOP) SHALL end the frame: sched_rden SHALL drop on the next cycle, and the state SHALL return to IDLE.
REQ-012 If the word counter reaches max_len without EOP, the max_len-th word SHALL be written with bit16 forced to 1, err_cnt SHALL increment, and the state SHALL go to ABORT.
REQ-013 A word without SOP as the first word of a frame SHALL be written with bit17 forced to 1 and SHALL increment err_cnt.
REQ-014 A watchdog SHALL run in READ: 255 consecutive cycles without a granted dval SHALL move the state to ABORT and increment err_cnt.
REQ-015 ABORT SHALL hold sched_rden=0 for 4 cycles, dropping any late dval, and then return to IDLE.
REQ-016 err_cnt SHALL saturate at 8'hFF, and multiple error events in the same cycle SHALL add only 1.
REQ-017 A FIFO push and pop in the same cycle SHALL leave the occupancy unchanged; the max_len admission check SHALL make FIFO overflow unreachable.
REQ-018 A change of max_len during READ SHALL take effect at the next GRANT, because it is latched in GRANT.

Reset
REQ-019 On reset assertion: state=IDLE, sched_rden=0, FIFO emptied (fifo_empty=1), fifo_rd_dval=0, fifo_rd_data=0, busy=0, err_cnt=0, counters=0, last winner=4.
REQ-020 Reset asserted mid-frame SHALL discard the partial frame, and a reset release SHALL not create a spurious grant in the first cycle.

Configuration
REQ-021 With TYPE2_TX_SCHED_PRIO_EN defined, channel 4 SHALL win GRANT whenever chn_empty[4]=0 (strict priority), and round-robin SHALL apply among channels 0-3 only.
REQ-022 Without TYPE2_TX_SCHED_PRIO_EN, all 5 channels SHALL share plain round-robin per REQ-007.

Structure
REQ-023 A shared package SHALL hold: the state encoding, the channel count 5, the FIFO depth 64, the SOP/EOP bit positions, and the watchdog limit 255.
REQ-024 The FIFO SHALL be the sub-module type2_tx_sched_fifo; arbitration and the FSM SHALL stay in the top level.

Verification
REQ-025 Channels 0 and 2 non-empty, 3-word frames, max_len=8 -> grants are 0 then 2; the FIFO holds 6 words in order; err_cnt=0.
REQ-026 All 5 channels non-empty, repeated frames -> grant order 0,1,2,3,4,0; with PRIO_EN, channel 4 wins every arbitration while non-empty.
REQ-027 Frame without EOP, max_len=4 -> 4 words stored, the 4th with bit16=1; state goes to ABORT for 4 cycles; err_cnt=1.
REQ-028 Grant, then no dval for 255 cycles -> ABORT; err_cnt=1; sched_rden=0.
REQ-029 FIFO holds 60 words, max_len=8 -> no grant; pop 4 words -> grant issued.
REQ-030 Reset asserted mid-READ at word 2 -> all outputs take their REQ-019 values immediately; after release, arbitration starts at channel 0.

Source files
------------

// File: rtl/type2_tx_sched_pkg.sv
// type2_tx_sched_pkg
// Shared definitions for the Type-2 transmit scheduler: FSM state encoding,
// channel count, output FIFO geometry, SOP/EOP bit positions, watchdog and
// abort timing, plus the round-robin index helper.
package type2_tx_sched_pkg;

    localparam int NUM_CHN      = 5;
    localparam int CHN_MPU      = 4;     // MPU configuration channel
    localparam int DATA_W       = 18;
    localparam int SOP_BIT      = 17;
    localparam int EOP_BIT      = 16;
    localparam int FIFO_DEPTH   = 64;
    localparam int FIFO_AW      = 6;
    localparam int WDOG_LIMIT   = 255;
    localparam int ABORT_CYCLES = 4;

    localparam logic [FIFO_AW:0] FIFO_FULL = FIFO_DEPTH[FIFO_AW:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_READ  = 2'd2,
        ST_ABORT = 2'd3
    } sched_state_t;

    function automatic logic [2:0] rr_next_idx(input logic [2:0] idx);
        return (idx == 3'(NUM_CHN - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/type2_tx_sched_fifo.sv
// type2_tx_sched_fifo
// 64 x 18 synchronous output FIFO. A pop request on a non-empty FIFO returns
// the word one cycle later with rd_vld_p1 high; a pop on an empty FIFO is
// ignored. Push and pop in the same cycle leave the level unchanged.
// Ports:
//   clk_12_5m, rst_12_5m_n  clock, async active-low reset
//   wr_vld_p0, wr_data_p0   write strobe and word
//   rd_req                  pop request
//   empty, level            status (level 0..64)
//   rd_vld_p1, rd_data_p1   popped word, one cycle after rd_req
module type2_tx_sched_fifo
    import type2_tx_sched_pkg::*;
(
    input  logic              clk_12_5m,
    input  logic              rst_12_5m_n,
    input  logic              wr_vld_p0,
    input  logic [DATA_W-1:0] wr_data_p0,
    input  logic              rd_req,
    output logic              empty,
    output logic [FIFO_AW:0]  level,
    output logic              rd_vld_p1,
    output logic [DATA_W-1:0] rd_data_p1
);

    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               push;
    logic               pop;

    assign empty = (level == '0);
    assign push  = wr_vld_p0 && (level != FIFO_FULL);
    assign pop   = rd_req && !empty;

    always_ff @(posedge clk_12_5m) begin
        if (push) begin
            mem[wr_ptr] <= wr_data_p0;
        end
    end

    // p0 -> p1: pointer/level update and registered read port
    always_ff @(posedge clk_12_5m or negedge rst_12_5m_n) begin
        if (!rst_12_5m_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            rd_vld_p1  <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level     <= level + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
            rd_vld_p1 <= pop;
            if (pop) rd_data_p1 <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/type2_tx_sched.sv
// type2_tx_sched
// Frame scheduler for five transmit channels into one 64-word output FIFO.
// A channel is granted only when the FIFO has room for a full max_len frame,
// so the FIFO can never overflow. Frames are repaired (SOP/EOP forced) and
// protocol errors counted in a saturating 8-bit counter.
// Optional build macro TYPE2_TX_SCHED_PRIO_EN: channel 4 (MPU config) gets
// strict priority, round-robin among channels 0-3. Default: plain 5-way RR.
// Ports:
//   clk_12_5m, rst_12_5m_n  clock, async active-low reset
//   chn_empty[4:0]          per-channel frame-empty flags
//   chn_dval[4:0]           per-channel word valid (one-hot or zero)
//   chn_data[17:0]          word from granted channel, bit17 SOP, bit16 EOP
//   max_len[6:0]            max frame length in words (1..64), latched in GRANT
//   sched_rden[4:0]         one-hot frame read request
//   fifo_rdreq              downstream pop
//   fifo_empty, fifo_rd_dval, fifo_rd_data  output FIFO read side
//   busy                    FSM not idle
//   err_cnt[7:0]            saturating error counter
module type2_tx_sched
    import type2_tx_sched_pkg::*;
(
    input  logic               clk_12_5m,
    input  logic               rst_12_5m_n,
    input  logic [NUM_CHN-1:0] chn_empty,
    input  logic [NUM_CHN-1:0] chn_dval,
    input  logic [DATA_W-1:0]  chn_data,
    input  logic [6:0]         max_len,
    output logic [NUM_CHN-1:0] sched_rden,
    input  logic               fifo_rdreq,
    output logic               fifo_empty,
    output logic               fifo_rd_dval,
    output logic [DATA_W-1:0]  fifo_rd_data,
    output logic               busy,
    output logic [7:0]         err_cnt
);

`ifdef TYPE2_TX_SCHED_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    sched_state_t       state_q, state_d;
    logic [NUM_CHN-1:0] grant_q;
    logic [2:0]         last_win_q;
    logic [6:0]         max_len_q;
    logic [6:0]         word_cnt_q;
    logic [7:0]         tmr_q;

    logic [NUM_CHN-1:0] req;
    logic [NUM_CHN-1:0] req_rr;
    logic [NUM_CHN-1:0] grant_oh;
    logic [2:0]         win_idx;
    logic [2:0]         cand;
    logic               win_found;
    logic [FIFO_AW:0]   fifo_level;
    logic               free_ok;
    logic               err_evt;
    logic               wr_vld_p0;
    logic [DATA_W-1:0]  wr_data_p0;

    assign req     = ~chn_empty;
    assign free_ok = (FIFO_FULL - fifo_level) >= max_len;

    // Round-robin search from last winner + 1; in priority builds channel 4
    // is removed from the rotation and overrides any RR result.
    always_comb begin
        req_rr = req;
        if (PRIO_EN) req_rr[CHN_MPU] = 1'b0;
        win_idx   = last_win_q;
        win_found = 1'b0;
        cand      = last_win_q;
        for (int i = 0; i < NUM_CHN; i++) begin
            cand = rr_next_idx(cand);
            if (!win_found && req_rr[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
        if (PRIO_EN && req[CHN_MPU]) begin
            win_idx   = 3'(CHN_MPU);
            win_found = 1'b1;
        end
        grant_oh          = '0;
        grant_oh[win_idx] = win_found;
    end

    // p0: frame checking / repair in front of the FIFO write port
    always_comb begin
        state_d    = state_q;
        err_evt    = 1'b0;
        wr_vld_p0  = 1'b0;
        wr_data_p0 = chn_data;
        case (state_q)
            ST_IDLE: begin
                if ((|req) && free_ok) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                state_d = win_found ? ST_READ : ST_IDLE;
            end
            ST_READ: begin
                if ((chn_dval != '0) && (chn_dval != grant_q)) err_evt = 1'b1;
                if (chn_dval == grant_q) begin
                    wr_vld_p0 = 1'b1;
                    if ((word_cnt_q == '0) && !chn_data[SOP_BIT]) begin
                        wr_data_p0[SOP_BIT] = 1'b1;
                        err_evt             = 1'b1;
                    end
                    if (chn_data[EOP_BIT]) begin
                        state_d = ST_IDLE;
                    end else if ((word_cnt_q + 7'd1) == max_len_q) begin
                        wr_data_p0[EOP_BIT] = 1'b1;
                        err_evt             = 1'b1;
                        state_d             = ST_ABORT;
                    end
                end else if (tmr_q == 8'(WDOG_LIMIT - 1)) begin
                    err_evt = 1'b1;
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (tmr_q == 8'(ABORT_CYCLES - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_12_5m or negedge rst_12_5m_n) begin
        if (!rst_12_5m_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            last_win_q <= 3'(NUM_CHN - 1);
            max_len_q  <= '0;
            word_cnt_q <= '0;
            tmr_q      <= '0;
            err_cnt    <= '0;
        end else begin
            state_q <= state_d;
            if (err_evt) err_cnt <= sat_inc(err_cnt);
            // tmr_q is the READ watchdog and the ABORT hold timer
            if (state_d != state_q) begin
                tmr_q <= '0;
            end else if (wr_vld_p0) begin
                tmr_q <= '0;
            end else if ((state_q == ST_READ) || (state_q == ST_ABORT)) begin
                tmr_q <= tmr_q + 8'd1;
            end
            if (state_q == ST_GRANT) begin
                grant_q    <= grant_oh;
                max_len_q  <= max_len;
                word_cnt_q <= '0;
                if (win_found && !(PRIO_EN && (win_idx == 3'(CHN_MPU)))) begin
                    last_win_q <= win_idx;
                end
            end else if (wr_vld_p0) begin
                word_cnt_q <= word_cnt_q + 7'd1;
            end
        end
    end

    assign sched_rden = (state_q == ST_READ) ? grant_q : '0;
    assign busy       = (state_q != ST_IDLE);

    type2_tx_sched_fifo u_fifo (
        .clk_12_5m   (clk_12_5m),
        .rst_12_5m_n (rst_12_5m_n),
        .wr_vld_p0   (wr_vld_p0),
        .wr_data_p0  (wr_data_p0),
        .rd_req      (fifo_rdreq),
        .empty       (fifo_empty),
        .level       (fifo_level),
        .rd_vld_p1   (fifo_rd_dval),
        .rd_data_p1  (fifo_rd_data)
    );

endmodule

// File: tb/tb_type2_tx_sched.sv
module tb_type2_tx_sched;

    logic        clk_12_5m = 1'b0;
    logic        rst_12_5m_n;
    logic [4:0]  chn_empty;
    logic [4:0]  chn_dval;
    logic [17:0] chn_data;
    logic [6:0]  max_len;
    logic [4:0]  sched_rden;
    logic        fifo_rdreq;
    logic        fifo_empty;
    logic        fifo_rd_dval;
    logic [17:0] fifo_rd_data;
    logic        busy;
    logic [7:0]  err_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    int          frame_no = 0;
    logic [17:0] exp_q [$];

    always #40 clk_12_5m = ~clk_12_5m;

    type2_tx_sched dut (
        .clk_12_5m    (clk_12_5m),
        .rst_12_5m_n  (rst_12_5m_n),
        .chn_empty    (chn_empty),
        .chn_dval     (chn_dval),
        .chn_data     (chn_data),
        .max_len      (max_len),
        .sched_rden   (sched_rden),
        .fifo_rdreq   (fifo_rdreq),
        .fifo_empty   (fifo_empty),
        .fifo_rd_dval (fifo_rd_dval),
        .fifo_rd_data (fifo_rd_data),
        .busy         (busy),
        .err_cnt      (err_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst_12_5m_n = 1'b0;
        chn_empty   = '1;
        chn_dval    = '0;
        chn_data    = '0;
        fifo_rdreq  = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk_12_5m);
        rst_12_5m_n = 1'b1;
    endtask

    task automatic wait_grant(output logic [4:0] g, output bit ok);
        ok = 1'b0;
        g  = '0;
        for (int i = 0; i < 64; i++) begin
            if (sched_rden != '0) begin
                g  = sched_rden;
                ok = 1'b1;
                break;
            end
            @(negedge clk_12_5m);
        end
    endtask

    // Plays the granted channel: n words, optional SOP on the first and EOP
    // on the last, optional foreign-channel dval after the first word.
    task automatic send_frame(input int n, input bit sop, input bit eop, input bit intr,
                              output logic [4:0] g);
        bit          ok;
        int          ch;
        logic [15:0] pl;
        logic [17:0] e;
        wait_grant(g, ok);
        check_val("grant_seen", 32'(ok), 32'd1);
        if (!ok) return;
        ch = 0;
        for (int i = 0; i < 5; i++) if (g[i]) ch = i;
        for (int w = 0; w < n; w++) begin
            pl       = {4'(ch), 4'(frame_no), 8'(w)};
            chn_dval = g;
            chn_data = {sop && (w == 0), eop && (w == n - 1), pl};
            e        = {1'b1 && (w == 0), (eop && (w == n - 1)) || (w == int'(max_len) - 1), pl};
            exp_q.push_back(e);
            @(negedge clk_12_5m);
            if (intr && (w == 0)) begin
                chn_dval = (g == 5'b00001) ? 5'b00010 : 5'b00001;
                chn_data = 18'h0BEEF;
                @(negedge clk_12_5m);
            end
        end
        chn_dval = '0;
        chn_data = '0;
        check_val("rden_drop", 32'(sched_rden), 32'd0);
        frame_no++;
    endtask

    task automatic pop_check(input string tag);
        logic [17:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h0;
        fifo_rdreq = 1'b1;
        @(negedge clk_12_5m);
        fifo_rdreq = 1'b0;
        check_val({tag, "_dval"}, 32'(fifo_rd_dval), 32'd1);
        check_val(tag, 32'(fifo_rd_data), 32'(e));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] g;
        logic [4:0] exp_g;
        int         cnt;
        bit         ok;

        rst_12_5m_n = 1'b1;
        chn_empty   = '1;
        chn_dval    = '0;
        chn_data    = '0;
        fifo_rdreq  = 1'b0;
        max_len     = 7'd8;
        #5 rst_12_5m_n = 1'b0;
        repeat (3) @(negedge clk_12_5m);
        check_val("rst_rden",   32'(sched_rden),   32'd0);
        check_val("rst_empty",  32'(fifo_empty),   32'd1);
        check_val("rst_dval",   32'(fifo_rd_dval), 32'd0);
        check_val("rst_rddata", 32'(fifo_rd_data), 32'd0);
        check_val("rst_busy",   32'(busy),         32'd0);
        check_val("rst_err",    32'(err_cnt),      32'd0);
        rst_12_5m_n = 1'b1;

        // Channels 0 and 2, 3-word frames
        chn_empty = 5'b11010;
        send_frame(3, 1, 1, 0, g);
        check_val("A_gnt0", 32'(g), 32'h01);
        chn_empty[0] = 1'b1;
        send_frame(3, 1, 1, 0, g);
        check_val("A_gnt1", 32'(g), 32'h04);
        chn_empty = '1;
        check_val("A_err", 32'(err_cnt), 32'd0);
        repeat (6) pop_check("A_pop");
        @(negedge clk_12_5m);
        check_val("A_dval_off", 32'(fifo_rd_dval), 32'd0);
        check_val("A_empty",    32'(fifo_empty),   32'd1);
        fifo_rdreq = 1'b1;
        @(negedge clk_12_5m);
        fifo_rdreq = 1'b0;
        check_val("A_empty_pop_dval", 32'(fifo_rd_dval), 32'd0);
        check_val("A_empty_pop_empty", 32'(fifo_empty), 32'd1);
        chn_empty = 5'b11110;
        send_frame(1, 1, 1, 0, g);
        check_val("A_gnt2", 32'(g), 32'h01);
        chn_empty = '1;
        pop_check("A_ptr");

        // All channels non-empty
        apply_reset();
        max_len   = 7'd8;
        chn_empty = '0;
        for (int f = 0; f < 6; f++) begin
            send_frame(2, 1, 1, 0, g);
`ifdef TYPE2_TX_SCHED_PRIO_EN
            exp_g = 5'b10000;
`else
            exp_g = 5'b00001 << (f % 5);
`endif
            check_val("B_gnt", 32'(g), 32'(exp_g));
        end
        chn_empty = '1;
        check_val("B_err", 32'(err_cnt), 32'd0);

        // Frame without EOP, max_len 4
        apply_reset();
        max_len   = 7'd4;
        chn_empty = 5'b11110;
        send_frame(4, 1, 0, 0, g);
        chn_empty = '1;
        check_val("C_gnt", 32'(g), 32'h01);
        chn_dval = 5'b00001;
        chn_data = 18'h2AAAA;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) cnt++;
            @(negedge clk_12_5m);
            chn_dval = '0;
            chn_data = '0;
        end
        check_val("C_abort_cycles", 32'(cnt), 32'd4);
        check_val("C_err", 32'(err_cnt), 32'd1);
        repeat (4) pop_check("C_pop");
        check_val("C_empty", 32'(fifo_empty), 32'd1);

        // Missing SOP with max_len 1 (two errors in one cycle), then foreign dval
        apply_reset();
        max_len   = 7'd1;
        chn_empty = 5'b11101;
        send_frame(1, 0, 0, 0, g);
        check_val("D_gnt0", 32'(g), 32'h02);
        check_val("D_err1", 32'(err_cnt), 32'd1);
        max_len = 7'd8;
        send_frame(3, 1, 1, 1, g);
        check_val("D_gnt1", 32'(g), 32'h02);
        chn_empty = '1;
        check_val("D_err2", 32'(err_cnt), 32'd2);
        repeat (4) pop_check("D_pop");
        check_val("D_empty", 32'(fifo_empty), 32'd1);

        // Watchdog
        apply_reset();
        max_len   = 7'd8;
        chn_empty = 5'b11110;
        wait_grant(g, ok);
        check_val("E_grant", 32'(ok), 32'd1);
        chn_empty = '1;
        cnt = 0;
        for (int i = 0; i < 300 && sched_rden != '0; i++) begin
            cnt++;
            @(negedge clk_12_5m);
        end
        check_val("E_wdog_cycles", 32'(cnt), 32'd255);
        check_val("E_err",  32'(err_cnt),    32'd1);
        check_val("E_rden", 32'(sched_rden), 32'd0);
        check_val("E_busy", 32'(busy),       32'd1);

        // Admission check against FIFO free space
        apply_reset();
        max_len   = 7'd8;
        chn_empty = 5'b11110;
        for (int f = 0; f < 8; f++) send_frame((f < 7) ? 8 : 4, 1, 1, 0, g);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) cnt++;
            @(negedge clk_12_5m);
        end
        check_val("F_no_grant", 32'(cnt), 32'd0);
        check_val("F_err", 32'(err_cnt), 32'd0);
        repeat (4) pop_check("F_pop");
        wait_grant(g, ok);
        check_val("F_grant_ok", 32'(ok), 32'd1);
        check_val("F_gnt", 32'(g), 32'h01);

        // Reset mid-READ after two words
        apply_reset();
        max_len   = 7'd8;
        chn_empty = 5'b11110;
        wait_grant(g, ok);
        check_val("G_grant", 32'(ok), 32'd1);
        chn_dval = g;
        chn_data = 18'h20100;
        @(negedge clk_12_5m);
        chn_data   = 18'h00101;
        fifo_rdreq = 1'b1;
        @(negedge clk_12_5m);
        fifo_rdreq = 1'b0;
        chn_dval   = '0;
        chn_data   = '0;
        chn_empty  = '0;
        check_val("G_pop_dval", 32'(fifo_rd_dval), 32'd1);
        check_val("G_pop_data", 32'(fifo_rd_data), 32'h20100);
        rst_12_5m_n = 1'b0;
        #1;
        check_val("G_rst_rden",   32'(sched_rden),   32'd0);
        check_val("G_rst_empty",  32'(fifo_empty),   32'd1);
        check_val("G_rst_dval",   32'(fifo_rd_dval), 32'd0);
        check_val("G_rst_rddata", 32'(fifo_rd_data), 32'd0);
        check_val("G_rst_busy",   32'(busy),         32'd0);
        check_val("G_rst_err",    32'(err_cnt),      32'd0);
        repeat (2) @(negedge clk_12_5m);
        rst_12_5m_n = 1'b1;
        @(negedge clk_12_5m);
        check_val("G_no_spurious", 32'(sched_rden), 32'd0);
        wait_grant(g, ok);
        check_val("G_regrant_ok", 32'(ok), 32'd1);
`ifdef TYPE2_TX_SCHED_PRIO_EN
        check_val("G_regrant", 32'(g), 32'h10);
`else
        check_val("G_regrant", 32'(g), 32'h01);
`endif
        chn_empty = '1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
